// File: rtl/cnna_pkg.sv
// Shared constants and FSM encodings for the ibuf stream reader and its skid FIFO.
package cnna_pkg;

  localparam int IBUF_ASIZE = 10;
  localparam int IBUF_DSIZE = 128;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] ibuf_rd_state_t;

  localparam ibuf_rd_state_t ST_IDLE  = 2'd0;
  localparam ibuf_rd_state_t ST_RUN   = 2'd1;
  localparam ibuf_rd_state_t ST_DRAIN = 2'd2;
  localparam ibuf_rd_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ibuf_skid_fifo.sv
// Two-entry register FIFO holding {tlast, data}; absorbs the one-cycle RAM read latency.
module ibuf_skid_fifo
  import cnna_pkg::*;
#(
  parameter int DW = IBUF_DSIZE
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  input  logic          push,
  input  logic [DW:0]   push_data,
  input  logic          pop,
  output logic [DW:0]   head,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW:0] mem [SKID_DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/ibuf_stream_rd.sv
// Streams I_len ibuf RAM words from I_base_raddr as valid/ready beats with tlast.
// Define IBUF_RD_PERF_EN to add O_stall_cnt (cycles with valid high and ready low).
//
// state | meaning
// IDLE  | waiting for I_start
// RUN   | issuing RAM reads under FIFO credit
// DRAIN | all reads issued; waiting for the FIFO to empty
// DONE  | one-cycle done pulse
module ibuf_stream_rd
  import cnna_pkg::*;
#(
  parameter int ASIZE = IBUF_ASIZE,
  parameter int DSIZE = IBUF_DSIZE
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_start,
  input  logic [ASIZE-1:0] I_base_raddr,
  input  logic [ASIZE:0]   I_len,
  output logic             O_busy,
  output logic             O_done,
  output logic [ASIZE-1:0] O_raddr,
  output logic             O_rd,
  input  logic [DSIZE-1:0] I_rdata,
  output logic             O_tvalid,
  input  logic             I_tready,
  output logic [DSIZE-1:0] O_tdata,
  output logic             O_tlast
`ifdef IBUF_RD_PERF_EN
  ,
  output logic [31:0]      O_stall_cnt
`endif
);

  ibuf_rd_state_t   state;
  logic [ASIZE-1:0] base_q;
  logic [ASIZE:0]   len_q;
  logic [ASIZE:0]   issued;
  logic [ASIZE:0]   issued_nxt;
  logic             rd_inflight;
  logic             rd_last_q;
  logic             last_rd;
  logic             pop;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_cnt;
  logic [2:0]       committed;
  logic             drain_ok;
  logic [DSIZE:0]   fifo_head;

  assign pop        = O_tvalid && I_tready;
  // A beat leaving this cycle frees its slot, which keeps reads back-to-back under full ready.
  assign committed  = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
  assign issued_nxt = issued + {{ASIZE{1'b0}}, 1'b1};
  assign last_rd    = (issued_nxt == len_q);
  assign O_rd       = (state == ST_RUN) && (committed < 3'd2);
  assign O_raddr    = base_q + issued[ASIZE-1:0];
  assign O_busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign O_done     = (state == ST_DONE);
  assign drain_ok   = !rd_inflight && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));
  assign fifo_push  = rd_inflight && (!fifo_full || pop);

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued      <= '0;
      rd_inflight <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      rd_inflight <= O_rd;
      rd_last_q   <= O_rd && last_rd;
      if (O_rd) issued <= issued_nxt;
      case (state)
        ST_IDLE: begin
          if (I_start) begin
            base_q <= I_base_raddr;
            len_q  <= I_len;
            issued <= '0;
            state  <= (I_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN:   if (O_rd && last_rd) state <= ST_DRAIN;
        ST_DRAIN: if (drain_ok) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  ibuf_skid_fifo #(.DW(DSIZE)) u_fifo (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .push      (fifo_push),
    .push_data ({rd_last_q, I_rdata}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign O_tvalid = !fifo_empty;
  assign O_tlast  = fifo_head[DSIZE];
  assign O_tdata  = fifo_head[DSIZE-1:0];

`ifdef IBUF_RD_PERF_EN
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      O_stall_cnt <= '0;
    end else if ((state == ST_IDLE) && I_start) begin
      O_stall_cnt <= '0;
    end else if (O_tvalid && !I_tready && (O_stall_cnt != 32'hFFFF_FFFF)) begin
      O_stall_cnt <= O_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
